// File: rtl/comparator_pipe.sv
// ---------------------------------------------------------------------------
// comparator_pipe
//   Pipelined signed/unsigned magnitude comparator for the branch/SLT path.
//   Operand pairs enter under a valid/ready handshake. Results leave STAGES
//   cycles later as greater/equal/lesser flags plus a RISC-V branch-taken
//   decision selected by funct3. Supports backpressure (bubbles collapse) and
//   a synchronous flush.
//
// Ports
//   clk_i      clock, all state on the rising edge
//   rst_i      synchronous active-high reset (priority over everything)
//   flush_i    drop every in-flight entry and any input offered this cycle
//   valid_i    input operands valid
//   ready_o    block can accept an input this cycle
//   A_i, B_i   operands, WIDTH bits
//   signed_i   1: two's-complement flags, 0: unsigned flags
//   funct3_i   branch code (BEQ/BNE/BLT/BGE/BLTU/BGEU)
//   valid_o    result valid
//   ready_i    consumer accepts result
//   greater_o  A > B
//   equal_o    A == B
//   lesser_o   A < B
//   taken_o    branch condition true for funct3
//   illegal_o  funct3 is 010 or 011 (taken_o forced 0)
// ---------------------------------------------------------------------------
module comparator_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  input  logic             signed_i,
  input  logic [2:0]       funct3_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             greater_o,
  output logic             equal_o,
  output logic             lesser_o,
  output logic             taken_o,
  output logic             illegal_o
);

  // Payload layout: {greater, equal, lesser, taken, illegal}
  localparam int PW = 5;

  logic [STAGES-1:0] vld_r;
  logic [PW-1:0]     pl_r [STAGES];
  logic [STAGES-1:0] adv_s;
  logic [PW-1:0]     pl_in_s;

  logic              eq_s;
  logic              lt_u_s;
  logic              lt_s_s;
  logic              lt_sel_s;
  logic              taken_s;
  logic              illegal_s;

  // Stage advance: a stage moves when it or any stage downstream of it is
  // empty, or when the consumer takes the result (bubbles collapse).
  always_comb begin
    logic full_v;
    adv_s = '0;
    for (int k = 0; k < STAGES; k++) begin
      full_v = 1'b1;
      for (int j = k; j < STAGES; j++) begin
        full_v = full_v & vld_r[j];
      end
      adv_s[k] = ready_i | ~full_v;
    end
  end

  assign ready_o = adv_s[0];

  // Compare and branch decision on the incoming pair. Flipping the MSB of
  // both operands turns a two's-complement compare into an unsigned one.
  always_comb begin
    eq_s      = (A_i == B_i);
    lt_u_s    = (A_i < B_i);
    lt_s_s    = ({~A_i[WIDTH-1], A_i[WIDTH-2:0]} < {~B_i[WIDTH-1], B_i[WIDTH-2:0]});
    lt_sel_s  = signed_i ? lt_s_s : lt_u_s;
    taken_s   = 1'b0;
    illegal_s = 1'b0;
    case (funct3_i)
      3'b000:  taken_s = eq_s;
      3'b001:  taken_s = ~eq_s;
      3'b100:  taken_s = lt_s_s;
      3'b101:  taken_s = ~lt_s_s;
      3'b110:  taken_s = lt_u_s;
      3'b111:  taken_s = ~lt_u_s;
      3'b010:  illegal_s = 1'b1;
      3'b011:  illegal_s = 1'b1;
      default: illegal_s = 1'b1;
    endcase
    pl_in_s = {~eq_s & ~lt_sel_s, eq_s, lt_sel_s, taken_s, illegal_s};
  end

  // Pipeline registers. An empty stage always carries an all-zero payload,
  // so the output flags read 0 whenever valid_o is low.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      vld_r <= '0;
      for (int k = 0; k < STAGES; k++) begin
        pl_r[k] <= '0;
      end
    end else begin
      if (adv_s[0]) begin
        vld_r[0] <= valid_i;
        pl_r[0]  <= valid_i ? pl_in_s : {PW{1'b0}};
      end
      for (int k = 1; k < STAGES; k++) begin
        if (adv_s[k]) begin
          vld_r[k] <= vld_r[k-1];
          pl_r[k]  <= pl_r[k-1];
        end
      end
    end
  end

  assign valid_o = vld_r[STAGES-1];
  assign {greater_o, equal_o, lesser_o, taken_o, illegal_o} = pl_r[STAGES-1];

endmodule

// File: tb/tb_comparator_pipe.sv
module tb_comparator_pipe;

  localparam int W = 32;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         flush_i = 1'b0;
  logic         valid_i = 1'b0;
  logic         ready_o;
  logic [W-1:0] a_v = '0;
  logic [W-1:0] b_v = '0;
  logic         signed_v = 1'b0;
  logic [2:0]   funct3_v = 3'b000;
  logic         valid_o;
  logic         ready_i = 1'b1;
  logic         greater_o, equal_o, lesser_o, taken_o, illegal_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int last_stall = -1;
  bit rnd_done = 1'b0;

  logic [4:0] exp_q[$];
  int         acc_q[$];

  always #5 clk = ~clk;

  comparator_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
    .ready_o(ready_o), .A_i(a_v), .B_i(b_v), .signed_i(signed_v),
    .funct3_i(funct3_v), .valid_o(valid_o), .ready_i(ready_i),
    .greater_o(greater_o), .equal_o(equal_o), .lesser_o(lesser_o),
    .taken_o(taken_o), .illegal_o(illegal_o)
  );

  // Reference: {greater, equal, lesser, taken, illegal} from plain arithmetic
  function automatic logic [4:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s, input logic [2:0] f);
    logic gt, eq, lt, tk, il;
    eq = (a == b);
    gt = s ? ($signed(a) > $signed(b)) : (a > b);
    lt = s ? ($signed(a) < $signed(b)) : (a < b);
    tk = 1'b0;
    il = (f == 3'd2) || (f == 3'd3);
    case (f)
      3'd0: tk = eq;
      3'd1: tk = !eq;
      3'd4: tk = $signed(a) < $signed(b);
      3'd5: tk = !($signed(a) < $signed(b));
      3'd6: tk = a < b;
      3'd7: tk = !(a < b);
      default: tk = 1'b0;
    endcase
    return {gt, eq, lt, tk, il};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor / scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    logic [4:0] got;
    logic [4:0] exp;
    int acc;
    int lat;
    got = {greater_o, equal_o, lesser_o, taken_o, illegal_o};
    chk("ready_o", {31'd0, ready_o}, {31'd0, !(exp_q.size() == S && !ready_i)});
    if (!valid_o) begin
      chk("idle_flags", {27'd0, got}, 32'd0);
    end else begin
      chk("one_hot", {30'd0, 2'(greater_o + equal_o + lesser_o)}, 32'd1);
    end
    if (!ready_i) last_stall = cyc;
    if (rst_i || flush_i) begin
      exp_q.delete();
      acc_q.delete();
    end else begin
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          exp = exp_q.pop_front();
          acc = acc_q.pop_front();
          chk("result", {27'd0, got}, {27'd0, exp});
          lat = cyc - acc;
          if (last_stall < acc) chk("latency", lat, S);
          else chk("latency_min", {31'd0, lat >= S}, 32'd1);
        end
      end
      if (valid_i && ready_o) begin
        exp_q.push_back(ref_model(a_v, b_v, signed_v, funct3_v));
        acc_q.push_back(cyc);
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic s, input logic [2:0] f);
    bit acc;
    bit done;
    a_v = a; b_v = b; signed_v = s; funct3_v = f; valid_i = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      acc = ready_o;
      @(posedge clk);
      #1;
      if (acc) done = 1'b1;
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return {1'b1, {(W-1){1'b0}}};
      3: return {1'b0, {(W-1){1'b1}}};
      4: return {{(W-1){1'b0}}, 1'b1};
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [2:0] pick_f3();
    return 3'($urandom_range(0, 7));
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] r;
    // 1: reset held two cycles with valid_i asserted
    rst_i = 1'b1; valid_i = 1'b1; a_v = 32'h1111_2222; b_v = 32'h3333_4444;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_i = 1'b0; valid_i = 1'b0;
    @(negedge clk);
    chk("rst_valid_o", {31'd0, valid_o}, 32'd0);
    chk("rst_ready_o", {31'd0, ready_o}, 32'd1);
    chk("rst_flags", {27'd0, greater_o, equal_o, lesser_o, taken_o, illegal_o}, 32'd0);
    @(posedge clk);
    #1;

    // 2: unsigned compares
    ready_i = 1'b1;
    send(32'hfedcba98, 32'h12345678, 1'b0, 3'b000);
    send(32'h12345678, 32'hfedcba98, 1'b0, 3'b001);
    send(32'hfedcba98, 32'hfedcba98, 1'b0, 3'b000);
    idle(4);

    // 3: signed compares and branch codes
    send(32'hfedcba98, 32'h12345678, 1'b1, 3'b100);
    send(32'h80000000, 32'h7fffffff, 1'b1, 3'b100);
    send(32'h80000000, 32'h7fffffff, 1'b1, 3'b110);
    send(32'h00000000, 32'hffffffff, 1'b0, 3'b110);
    send(32'hffffffff, 32'h00000000, 1'b1, 3'b101);
    send(32'h80000000, 32'h80000000, 1'b0, 3'b111);
    idle(4);

    // 4: streaming with backpressure on cycles 3-5
    fork
      begin
        for (int i = 0; i < 6; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)), pick_f3());
        valid_i = 1'b0;
      end
      begin
        repeat (2) @(posedge clk);
        #1 ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 ready_i = 1'b1;
      end
    join
    idle(6);

    // 5: flush with two entries in flight; the pair offered alongside is dropped
    ready_i = 1'b0;
    send(32'h5, 32'h6, 1'b0, 3'b000);
    send(32'h7, 32'h7, 1'b0, 3'b000);
    ready_i = 1'b1; flush_i = 1'b1; valid_i = 1'b1; a_v = 32'h9; b_v = 32'h1;
    @(posedge clk);
    #1;
    flush_i = 1'b0; valid_i = 1'b0;
    @(negedge clk);
    chk("flush_valid_o", {31'd0, valid_o}, 32'd0);
    @(posedge clk);
    #1;
    send(32'hdeadbeef, 32'h0badf00d, 1'b1, 3'b101);
    idle(4);

    // 6: illegal branch codes
    send(32'h0, 32'h0, 1'b0, 3'b010);
    send(32'h0, 32'h0, 1'b1, 3'b011);
    idle(4);

    // 7: randomized traffic with random backpressure and occasional flush
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 39) == 0) begin
            flush_i = 1'b1; valid_i = 1'($urandom_range(0, 1));
            a_v = pick(); b_v = pick();
            @(posedge clk);
            #1;
            flush_i = 1'b0; valid_i = 1'b0;
          end else if ($urandom_range(0, 3) == 0) begin
            idle(1);
          end else begin
            send(pick(), pick(), 1'($urandom_range(0, 1)), pick_f3());
          end
          if (i == 150) begin
            valid_i = 1'b1; r = $urandom; a_v = r; b_v = r;
            rst_i = 1'b1;
            @(posedge clk);
            #1;
            rst_i = 1'b0; valid_i = 1'b0;
            @(negedge clk);
            chk("midrst_valid_o", {31'd0, valid_o}, 32'd0);
            chk("midrst_flags", {27'd0, greater_o, equal_o, lesser_o, taken_o, illegal_o}, 32'd0);
            @(posedge clk);
            #1;
          end
        end
        valid_i = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          ready_i = ($urandom_range(0, 3) != 0);
        end
        ready_i = 1'b1;
      end
    join

    // drain
    ready_i = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
